mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares the core's single byte-lane memory port between the instruction-fetch requester and the load/store requester of mips_core.
- Serialises accesses and applies a fixed memory latency.
- Data port has priority, with a bounded-starvation guarantee for fetch.
- Sits between the core datapath (fetch/PC logic and the ALU-result address path) and the 4x8-bit memory.

Parameters:
MEM_LAT, 1, memory read latency in cycles (legal range 1..15).
STARVE_MAX, 4, maximum consecutive data grants while fetch is waiting (legal range 1..15).

Ports:
clk  in  1  clock; all state updates on rising edge.
rst_b  in  1  synchronous reset, active-high (port keeps the codebase name; asserted = 1).
halted  in  1  core halted; blocks new grants.
if_req  in  1  fetch request; held with if_addr until if_ready.
if_addr  in  32  fetch byte address.
if_ready  out  1  fetch grant (combinational).
if_rdata  out  32  fetched word; holds last value.
if_rvalid  out  1  one-cycle fetch response pulse.
d_req  in  1  data request; held with d_we/d_addr/d_wdata until d_ready.
d_we  in  1  1 = store, 0 = load.
d_addr  in  32  data byte address.
d_wdata  in  32  store word.
d_ready  out  1  data grant (combinational).
d_rdata  out  32  loaded word; holds last value.
d_rvalid  out  1  one-cycle data response pulse (loads and stores).
d_misalign  out  1  one-cycle pulse, coincident with d_rvalid, if granted d_addr[1:0] != 0.
mem_addr  out  32  word address to memory, {addr[31:2],2'b00}.
mem_data_in  out  8 x [0:3]  store lanes to memory.
mem_data_out  in  8 x [0:3]  read lanes from memory.
mem_write_en  out  1  memory write strobe.
busy  out  1  1 whenever state != IDLE.

Behaviour:
- Reset (rst_b = 1 at an edge): state IDLE, latency counter 0, streak counter 0. All outputs 0, including rdata registers, lanes and mem_addr. Aborts any in-flight access: no rvalid, no write strobe next cycle.
- Lane order: word = {lane[0], lane[1], lane[2], lane[3]}; lane[0] carries bits 31:24, same for reads and writes.
- States: IDLE, ACCESS, RESP.
- Grants happen only in IDLE with halted = 0. At most one of if_ready/d_ready is high per cycle. Grant = req & ready at a rising edge (cycle N).
- Arbitration, in IDLE:
  - Only one requester active: it wins.
  - Both active: data wins unless the streak counter equals STARVE_MAX, in which case fetch wins.
- Streak counter:
  - Increments on a data grant while if_req = 1, saturating at STARVE_MAX.
  - Clears on any fetch grant, and on a data grant while if_req = 0.
- At grant: register the access. mem_addr is valid from cycle N+1 until the return to IDLE.
- Read (fetch, or load):
  - ACCESS lasts MEM_LAT cycles (N+1 .. N+MEM_LAT).
  - mem_data_out is sampled at the end of cycle N+MEM_LAT.
  - RESP in cycle N+MEM_LAT+1: rvalid = 1 and rdata valid. rdata holds until overwritten by the next response of the same port.
- Store:
  - ACCESS lasts exactly 1 cycle (N+1), with mem_write_en = 1 and lanes driven from d_wdata.
  - RESP in N+2 with d_rvalid = 1; d_rdata unchanged.
  - mem_write_en is 0 in all other cycles.
- RESP always moves to IDLE. A new grant is possible in cycle N+MEM_LAT+2 (read) or N+3 (store).
- Halted rising mid-access: the in-flight access completes normally; no further grants.
- Misaligned address: the access proceeds with the low bits forced to 0; d_misalign pulses with d_rvalid. Fetch misalignment is ignored.
- Request dropped before grant: not a protocol violation; no access occurs.

Decomposition:
- Shared package mips_pkg:
  - arb_state_t enum {IDLE, ACCESS, RESP};
  - port-id enum {PORT_IF, PORT_D};
  - functions lanes_to_word / word_to_lanes;
  - default constants for MEM_LAT and STARVE_MAX.
- One sub-module, mem_arb_pick: combinational winner selection plus the streak counter register. Inputs if_req, d_req, grant_ok, plus clk and rst_b. Outputs if_ready, d_ready.

Test Plan:
- Single fetch, MEM_LAT = 3, if_addr = 0x0000_0040, memory returns lanes {DE,AD,BE,EF}:
  - if_rvalid pulses exactly 4 cycles after grant;
  - if_rdata = 0xDEADBEEF;
  - mem_addr = 0x40 during ACCESS.
- Store d_addr = 0x0000_0104, d_wdata = 0x1122_3344:
  - mem_write_en high for exactly one cycle;
  - lanes = {11,22,33,44};
  - d_rvalid two cycles after grant;
  - no fetch grant in between.
- if_req and d_req held continuously, STARVE_MAX = 4 (no halt, no reset): grant sequence D,D,D,D,IF,D,D,D,D,IF…
- Load d_addr = 0x0000_0007: mem_addr = 0x0000_0004; d_misalign and d_rvalid pulse together.
- Reset mid-ACCESS of a read:
  - next cycle state IDLE;
  - no rvalid;
  - rdata registers = 0;
  - a pending request is granted in the first cycle after reset deasserts.
- halted = 1 asserted one cycle after a load grant: load completes with d_rvalid; further if_req/d_req never see ready while halted = 1.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and helpers for the mips_core memory-port arbiter.
// A word is lane[0..3], and lane[0] holds bits 31:24.
package mips_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} arb_state_t;
  typedef enum logic {PORT_IF, PORT_D} port_id_t;
  typedef logic [0:3][7:0] lanes_t;

  localparam int DEF_MEM_LAT    = 1;
  localparam int DEF_STARVE_MAX = 4;

  function automatic logic [31:0] lanes_to_word(input lanes_t lanes);
    return {lanes[0], lanes[1], lanes[2], lanes[3]};
  endfunction

  function automatic lanes_t word_to_lanes(input logic [31:0] word);
    lanes_t lanes;
    lanes[0] = word[31:24];
    lanes[1] = word[23:16];
    lanes[2] = word[15:8];
    lanes[3] = word[7:0];
    return lanes;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Picks the winner for the shared memory port. Data normally wins a tie.
// A streak counter lets fetch win after STARVE_MAX back-to-back data grants.
module mem_arb_pick
  import mips_pkg::*;
#(
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic clk,
  input  logic rst_b,
  input  logic if_req,
  input  logic d_req,
  input  logic grant_ok,
  output logic if_ready,
  output logic d_ready
);

  localparam logic [3:0] STREAK_CAP = 4'(STARVE_MAX);

  logic [3:0] streak;
  logic       fetch_starved;

  // NOTE: every output of this always_comb is assigned on every path, so no latch is inferred.
  always_comb begin
    fetch_starved = (streak == STREAK_CAP);
    if_ready      = grant_ok & if_req & (~d_req | fetch_starved);
    d_ready       = grant_ok & d_req & ~(if_req & fetch_starved);
  end

  // A data grant with fetch waiting implies streak < cap, so the increment saturates by itself.
  // NOTE: sequential state uses <= so each flop sees the pre-edge value of the others.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      streak <= '0;
    end else if (if_ready) begin
      streak <= '0;
    end else if (d_ready) begin
      streak <= if_req ? streak + 4'd1 : '0;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and load/store accesses onto the single 4x8-bit memory port.
// Reads take MEM_LAT cycles and stores take one, and each access ends with a one-cycle response.
module mem_port_arbiter
  import mips_pkg::*;
#(
  parameter int MEM_LAT    = DEF_MEM_LAT,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             halted,
  input  logic             if_req,
  input  logic [31:0]      if_addr,
  output logic             if_ready,
  output logic [31:0]      if_rdata,
  output logic             if_rvalid,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [31:0]      d_addr,
  input  logic [31:0]      d_wdata,
  output logic             d_ready,
  output logic [31:0]      d_rdata,
  output logic             d_rvalid,
  output logic             d_misalign,
  output logic [31:0]      mem_addr,
  output logic [0:3][7:0]  mem_data_in,
  input  logic [0:3][7:0]  mem_data_out,
  output logic             mem_write_en,
  output logic             busy
);

  localparam logic [3:0] LAT_LAST = 4'(MEM_LAT - 1);

  arb_state_t state;
  port_id_t   port;
  logic       is_store;
  logic       addr_misalign;
  logic [3:0] lat_cnt;
  logic       grant_ok;

  assign grant_ok = (state == IDLE) && !halted;
  assign busy     = (state != IDLE);

  mem_arb_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
    .clk      (clk),
    .rst_b    (rst_b),
    .if_req   (if_req),
    .d_req    (d_req),
    .grant_ok (grant_ok),
    .if_ready (if_ready),
    .d_ready  (d_ready)
  );

  always_ff @(posedge clk) begin
    if (rst_b) begin
      state         <= IDLE;
      port          <= PORT_IF;
      is_store      <= 1'b0;
      addr_misalign <= 1'b0;
      lat_cnt       <= '0;
      mem_addr      <= '0;
      mem_data_in   <= '0;
      mem_write_en  <= 1'b0;
      if_rdata      <= '0;
      if_rvalid     <= 1'b0;
      d_rdata       <= '0;
      d_rvalid      <= 1'b0;
      d_misalign    <= 1'b0;
    end else begin
      // Pulse outputs default low and are raised only in the cycle that needs them.
      if_rvalid    <= 1'b0;
      d_rvalid     <= 1'b0;
      d_misalign   <= 1'b0;
      mem_write_en <= 1'b0;
      case (state)
        IDLE: begin
          if (d_ready) begin
            state         <= ACCESS;
            port          <= PORT_D;
            is_store      <= d_we;
            addr_misalign <= (d_addr[1:0] != 2'b00);
            mem_addr      <= d_addr & ~32'h3;
            lat_cnt       <= '0;
            if (d_we) begin
              mem_write_en <= 1'b1;
              mem_data_in  <= word_to_lanes(d_wdata);
            end
          end else if (if_ready) begin
            state         <= ACCESS;
            port          <= PORT_IF;
            is_store      <= 1'b0;
            addr_misalign <= 1'b0;
            mem_addr      <= if_addr & ~32'h3;
            lat_cnt       <= '0;
          end
        end
        ACCESS: begin
          if (is_store || lat_cnt == LAT_LAST) begin
            state <= RESP;
            if (port == PORT_D) begin
              d_rvalid   <= 1'b1;
              d_misalign <= addr_misalign;
              if (!is_store) d_rdata <= lanes_to_word(mem_data_out);
            end else begin
              if_rvalid <= 1'b1;
              if_rdata  <= lanes_to_word(mem_data_out);
            end
          end else begin
            lat_cnt <= lat_cnt + 4'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with MEM_LAT = 3 and STARVE_MAX = 4.
// Inputs change 1 ns after the falling edge. Outputs are sampled 1 ns after that.
module tb_mem_port_arbiter;

  logic            clk = 1'b0;
  logic            rst_b = 1'b1;
  logic            halted = 1'b0;
  logic            if_req = 1'b0;
  logic [31:0]     if_addr = '0;
  logic            if_ready;
  logic [31:0]     if_rdata;
  logic            if_rvalid;
  logic            d_req = 1'b0;
  logic            d_we = 1'b0;
  logic [31:0]     d_addr = '0;
  logic [31:0]     d_wdata = '0;
  logic            d_ready;
  logic [31:0]     d_rdata;
  logic            d_rvalid;
  logic            d_misalign;
  logic [31:0]     mem_addr;
  logic [0:3][7:0] mem_data_in;
  logic [0:3][7:0] mem_data_out = '0;
  logic            mem_write_en;
  logic            busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_LAT(3), .STARVE_MAX(4)) dut (
    .clk          (clk),
    .rst_b        (rst_b),
    .halted       (halted),
    .if_req       (if_req),
    .if_addr      (if_addr),
    .if_ready     (if_ready),
    .if_rdata     (if_rdata),
    .if_rvalid    (if_rvalid),
    .d_req        (d_req),
    .d_we         (d_we),
    .d_addr       (d_addr),
    .d_wdata      (d_wdata),
    .d_ready      (d_ready),
    .d_rdata      (d_rdata),
    .d_rvalid     (d_rvalid),
    .d_misalign   (d_misalign),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out),
    .mem_write_en (mem_write_en),
    .busy         (busy)
  );

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      if (!busy) break;
      step();
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL drain: busy=%b required 0", busy);
    end
  endtask

  task automatic test_reset();
    rst_b = 1'b1;
    repeat (2) step();
    rst_b = 1'b0;
    settle();
    checks++;
    if ({busy, if_ready, d_ready, if_rvalid, d_rvalid, d_misalign, mem_write_en} !== 7'b0) begin
      errors++; $display("FAIL reset_flags: got %b required 0000000",
        {busy, if_ready, d_ready, if_rvalid, d_rvalid, d_misalign, mem_write_en});
    end
    checks++;
    if ({mem_addr, if_rdata, d_rdata} !== 96'h0) begin
      errors++; $display("FAIL reset_regs: mem_addr=%h if_rdata=%h d_rdata=%h required 0",
        mem_addr, if_rdata, d_rdata);
    end
    checks++;
    if (mem_data_in !== 32'h0) begin
      errors++; $display("FAIL reset_lanes: got %h required 0", mem_data_in);
    end
  endtask

  task automatic test_fetch();
    mem_data_out = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
    step();
    if_req = 1'b1; if_addr = 32'h0000_0040;
    settle();
    checks++;
    if (!(if_ready === 1'b1 && d_ready === 1'b0)) begin
      errors++; $display("FAIL fetch_grant: if_ready=%b d_ready=%b required 1/0", if_ready, d_ready);
    end
    step();
    if_req = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      checks++;
      if (!(mem_addr === 32'h40 && if_rvalid === 1'b0 && busy === 1'b1)) begin
        errors++; $display("FAIL fetch_access%0d: mem_addr=%h if_rvalid=%b busy=%b required 00000040/0/1",
          k, mem_addr, if_rvalid, busy);
      end
      step();
    end
    checks++;
    if (!(if_rvalid === 1'b1 && if_rdata === 32'hDEAD_BEEF)) begin
      errors++; $display("FAIL fetch_resp: if_rvalid=%b if_rdata=%h required 1/deadbeef", if_rvalid, if_rdata);
    end
    step();
    checks++;
    if (!(if_rvalid === 1'b0 && busy === 1'b0)) begin
      errors++; $display("FAIL fetch_idle: if_rvalid=%b busy=%b required 0/0", if_rvalid, busy);
    end
  endtask

  task automatic test_starvation();
    int exp_seq [10] = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2};  // 1 = data, 2 = fetch
    int got;
    step();
    if_req = 1'b1; if_addr = 32'h0000_0080;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0200;
    for (int g = 0; g < 10; g++) begin
      got = 0;
      for (int c = 0; c < 20; c++) begin
        settle();
        if (if_ready && d_ready) got = 3;
        else if (if_ready)       got = 2;
        else if (d_ready)        got = 1;
        step();
        if (got != 0) break;
      end
      checks++;
      if (got != exp_seq[g]) begin
        errors++; $display("FAIL starve_grant%0d: got %0d required %0d", g, got, exp_seq[g]);
      end
    end
    if_req = 1'b0; d_req = 1'b0;
    drain();
  endtask

  task automatic test_store();
    step();
    if_req = 1'b1; if_addr = 32'h0000_0080;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0104; d_wdata = 32'h1122_3344;
    settle();
    checks++;
    if (!(d_ready === 1'b1 && if_ready === 1'b0)) begin
      errors++; $display("FAIL store_grant: d_ready=%b if_ready=%b required 1/0", d_ready, if_ready);
    end
    step();
    d_req = 1'b0; d_we = 1'b0;
    settle();
    checks++;
    if (!(mem_write_en === 1'b1 && mem_data_in === 32'h1122_3344 && mem_addr === 32'h104 &&
          d_rvalid === 1'b0 && if_ready === 1'b0)) begin
      errors++; $display("FAIL store_access: we=%b lanes=%h addr=%h rvalid=%b if_ready=%b required 1/11223344/00000104/0/0",
        mem_write_en, mem_data_in, mem_addr, d_rvalid, if_ready);
    end
    step();
    settle();
    checks++;
    if (!(d_rvalid === 1'b1 && mem_write_en === 1'b0 && d_misalign === 1'b0 &&
          if_ready === 1'b0 && d_rdata === 32'hDEAD_BEEF)) begin
      errors++; $display("FAIL store_resp: rvalid=%b we=%b mis=%b if_ready=%b d_rdata=%h required 1/0/0/0/deadbeef",
        d_rvalid, mem_write_en, d_misalign, if_ready, d_rdata);
    end
    step();
    settle();
    checks++;
    if (!(if_ready === 1'b1 && mem_write_en === 1'b0 && d_rvalid === 1'b0)) begin
      errors++; $display("FAIL store_after: if_ready=%b we=%b rvalid=%b required 1/0/0", if_ready, mem_write_en, d_rvalid);
    end
    if_req = 1'b0;  // dropped before the edge: no access must start
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL dropped_req: busy=%b required 0", busy);
    end
  endtask

  task automatic test_misalign();
    mem_data_out = {8'h01, 8'h02, 8'h03, 8'h04};
    step();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0007;
    settle();
    checks++;
    if (d_ready !== 1'b1) begin
      errors++; $display("FAIL mis_grant: d_ready=%b required 1", d_ready);
    end
    step();
    d_req = 1'b0;
    checks++;
    if (mem_addr !== 32'h0000_0004) begin
      errors++; $display("FAIL mis_addr: got %h required 00000004", mem_addr);
    end
    for (int k = 2; k <= 3; k++) begin
      step();
      checks++;
      if ({d_rvalid, d_misalign} !== 2'b00) begin
        errors++; $display("FAIL mis_early%0d: rvalid/mis=%b required 00", k, {d_rvalid, d_misalign});
      end
    end
    step();
    checks++;
    if (!({d_rvalid, d_misalign} === 2'b11 && d_rdata === 32'h0102_0304 && if_rdata === 32'hDEAD_BEEF)) begin
      errors++; $display("FAIL mis_resp: rvalid/mis=%b d_rdata=%h if_rdata=%h required 11/01020304/deadbeef",
        {d_rvalid, d_misalign}, d_rdata, if_rdata);
    end
    step();
    checks++;
    if ({d_rvalid, d_misalign} !== 2'b00) begin
      errors++; $display("FAIL mis_after: rvalid/mis=%b required 00", {d_rvalid, d_misalign});
    end
  endtask

  task automatic test_reset_mid();
    int d_seen = 0;
    int if_seen = 0;
    mem_data_out = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
    step();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0030;
    settle();
    checks++;
    if (d_ready !== 1'b1) begin
      errors++; $display("FAIL rst_mid_grant: d_ready=%b required 1", d_ready);
    end
    step();
    d_req = 1'b0; if_req = 1'b1; if_addr = 32'h0000_0044; rst_b = 1'b1;
    settle();
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL rst_mid_access: busy=%b required 1", busy);
    end
    step();
    rst_b = 1'b0;
    settle();
    checks++;
    if (!(busy === 1'b0 && d_rvalid === 1'b0 && if_rdata === 32'h0 && d_rdata === 32'h0 &&
          mem_addr === 32'h0 && if_ready === 1'b1)) begin
      errors++; $display("FAIL rst_mid_state: busy=%b rvalid=%b if_rdata=%h d_rdata=%h addr=%h if_ready=%b required 0/0/0/0/0/1",
        busy, d_rvalid, if_rdata, d_rdata, mem_addr, if_ready);
    end
    step();
    if_req = 1'b0;
    checks++;
    if (!(busy === 1'b1 && mem_addr === 32'h44)) begin
      errors++; $display("FAIL rst_mid_fetch: busy=%b addr=%h required 1/00000044", busy, mem_addr);
    end
    for (int k = 0; k < 5; k++) begin
      if (d_rvalid) d_seen++;
      if (if_rvalid) if_seen++;
      step();
    end
    checks++;
    if (!(d_seen == 0 && if_seen == 1 && if_rdata === 32'hAABB_CCDD)) begin
      errors++; $display("FAIL rst_mid_resp: d_rvalid pulses=%0d if_rvalid pulses=%0d if_rdata=%h required 0/1/aabbccdd",
        d_seen, if_seen, if_rdata);
    end
    drain();
  endtask

  task automatic test_halt();
    int bad_ready = 0;
    mem_data_out = {8'h55, 8'h66, 8'h77, 8'h88};
    step();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0050;
    settle();
    checks++;
    if (d_ready !== 1'b1) begin
      errors++; $display("FAIL halt_grant: d_ready=%b required 1", d_ready);
    end
    step();
    halted = 1'b1; if_req = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      settle();
      if (if_ready || d_ready || d_rvalid) bad_ready++;
      step();
    end
    settle();
    checks++;
    if (!(d_rvalid === 1'b1 && d_rdata === 32'h5566_7788 && bad_ready == 0)) begin
      errors++; $display("FAIL halt_resp: rvalid=%b d_rdata=%h early=%0d required 1/55667788/0",
        d_rvalid, d_rdata, bad_ready);
    end
    for (int k = 0; k < 4; k++) begin
      step();
      settle();
      if (if_ready || d_ready || busy) bad_ready++;
    end
    checks++;
    if (bad_ready != 0) begin
      errors++; $display("FAIL halt_block: ready/busy seen %0d times required 0", bad_ready);
    end
    halted = 1'b0;
    settle();
    checks++;
    if (!(d_ready === 1'b1 && if_ready === 1'b0)) begin
      errors++; $display("FAIL halt_release: d_ready=%b if_ready=%b required 1/0", d_ready, if_ready);
    end
    d_req = 1'b0; if_req = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_starvation();
    test_store();
    test_misalign();
    test_reset_mid();
    test_halt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
